// File: rtl/multiword_add_seq16.sv
// multiword_add_seq16: streams wide operands through one 16-bit carry-select
// adder, least-significant beat first, chaining each beat's carry-out into the
// next beat's carry-in. One registered sum beat is produced per input beat.
//
// Handshake (both sides): a beat moves when valid && ready in the same cycle.
// valid must hold its data stable until it is taken. in_ready is
// !out_valid || out_ready: a single output register with pass-through readiness.

// 16-bit carry-select adder: four 4-bit blocks, each computing both carry
// hypotheses in parallel, with the true carry picking the result.
module carry_select_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar g = 0; g < 4; g++) begin : g_blk
        logic [4:0] r0;
        logic [4:0] r1;

        // Both carry hypotheses for this block; 4-bit a+b+1 fits in 5 bits.
        assign r0 = {1'b0, a[4*g+3 -: 4]} + {1'b0, b[4*g+3 -: 4]};
        assign r1 = r0 + 5'd1;

        // Incoming carry picks the sum slice and the block carry-out.
        assign sum[4*g+3 -: 4] = c[g] ? r1[3:0] : r0[3:0];
        assign c[g+1]          = c[g] ? r1[4]   : r0[4];
    end

    assign cout = c[4];
endmodule

module multiword_add_seq16 #(
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_cin,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_last,
    output logic        out_cout,
    output logic        out_ovf,
    output logic        len_err
);
    localparam int            CW       = $clog2(WORDS) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);
    // With a single beat per packet every beat closes on its own, so a
    // missing in_last can never be a length violation.
    localparam logic          MULTI    = (WORDS > 1);

    logic          first;
    logic          carry;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          at_max;
    logic          close;
    logic          forced;
    logic          cin;
    logic [15:0]   sum;
    logic          cout;
    logic          ovf;

    // Output register drains or is empty -> upstream may push this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Packet boundary: explicit last beat, or the beat budget is used up.
    assign at_max = (cnt == LAST_CNT);
    assign close  = in_last || at_max;
    assign forced = accept && at_max && !in_last && MULTI;

    // First beat takes the packet carry-in; later beats take the chained carry.
    assign cin = first ? in_cin : carry;

    carry_select_adder16 u_adder (
        .a    (in_a),
        .b    (in_b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    // Signed overflow of the full-width sum, judged on the top beat only.
    assign ovf = (in_a[15] == in_b[15]) && (sum[15] != in_a[15]);

    // Output beat register: load on accept, drop valid on a bare retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_last  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= sum;
            out_cout  <= cout;
            out_last  <= close;
            out_ovf   <= close ? ovf : 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Packet tracking: beat count, chained carry and first-beat flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first <= 1'b1;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            if (close) begin
                first <= 1'b1;
                carry <= 1'b0;
                cnt   <= '0;
            end else begin
                first <= 1'b0;
                carry <= cout;
                cnt   <= cnt + CW'(1);
            end
        end
    end

    // Sticky length-violation flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_err <= 1'b0;
        end else if (forced) begin
            len_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_multiword_add_seq16.sv
// Bench for multiword_add_seq16: three instances (WORDS = 1, 2, 4) share the
// input bus; 'sel' picks which one receives in_valid and which one is observed.
module tb_multiword_add_seq16;
    localparam int W = 19;  // {last, cout, ovf, sum}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    int          sel = 4;

    logic        v1, v2, v4;
    logic        r1, r2, r4;
    logic        ov1, ov2, ov4;
    logic [15:0] s1, s2, s4;
    logic        l1, l2, l4;
    logic        c1, c2, c4;
    logic        o1, o2, o4;
    logic        e1, e2, e4;

    logic        cur_in_ready, cur_out_valid, cur_last, cur_cout, cur_ovf, cur_len_err;
    logic [15:0] cur_sum;

    int checks = 0;
    int errors = 0;

    logic [15:0] stim_a[$];
    logic [15:0] stim_b[$];
    logic        stim_cin[$];
    logic        stim_last[$];
    logic [W-1:0] exp_q[$];

    // Clock and input steering
    always #5 clk = ~clk;

    assign v1 = in_valid && (sel == 1);
    assign v2 = in_valid && (sel == 2);
    assign v4 = in_valid && (sel == 4);

    multiword_add_seq16 #(.WORDS(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
        .out_sum(s1), .out_last(l1), .out_cout(c1), .out_ovf(o1), .len_err(e1)
    );
    multiword_add_seq16 #(.WORDS(2)) u_w2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_last(in_last), .out_valid(ov2), .out_ready(out_ready),
        .out_sum(s2), .out_last(l2), .out_cout(c2), .out_ovf(o2), .len_err(e2)
    );
    multiword_add_seq16 #(.WORDS(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_last(in_last), .out_valid(ov4), .out_ready(out_ready),
        .out_sum(s4), .out_last(l4), .out_cout(c4), .out_ovf(o4), .len_err(e4)
    );

    // Observe the selected instance
    always_comb begin
        cur_in_ready  = r4;
        cur_out_valid = ov4;
        cur_sum       = s4;
        cur_last      = l4;
        cur_cout      = c4;
        cur_ovf       = o4;
        cur_len_err   = e4;
        if (sel == 1) begin
            cur_in_ready = r1; cur_out_valid = ov1; cur_sum = s1; cur_last = l1;
            cur_cout = c1; cur_ovf = o1; cur_len_err = e1;
        end else if (sel == 2) begin
            cur_in_ready = r2; cur_out_valid = ov2; cur_sum = s2; cur_last = l2;
            cur_cout = c2; cur_ovf = o2; cur_len_err = e2;
        end
    end

    // Queue one input beat together with its hand-computed output beat.
    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic last, input logic [15:0] e_sum, input logic e_cout,
                        input logic e_last, input logic e_ovf);
        stim_a.push_back(a);
        stim_b.push_back(b);
        stim_cin.push_back(cin);
        stim_last.push_back(last);
        exp_q.push_back({e_last, e_cout, e_ovf, e_sum});
    endtask

    // Driver plus scoreboard: feeds queued beats to the selected instance and
    // retires output beats against exp_q. mode 0: ready=1, 1: 1,0,0,1 pattern,
    // 2: random ready.
    task automatic run_stream(input string name, input int mode, input int max_cycles);
        int idx = 0;
        int cyc = 0;
        logic [W-1:0] exp_v;
        logic [W-1:0] got;
        while ((idx < stim_a.size() || exp_q.size() > 0) && cyc < max_cycles) begin
            @(negedge clk);
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            else                out_ready = 1'($urandom_range(0, 1));
            if (idx < stim_a.size()) begin
                in_valid = 1'b1;
                in_a     = stim_a[idx];
                in_b     = stim_b[idx];
                in_cin   = stim_cin[idx];
                in_last  = stim_last[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++;
            if (cur_in_ready !== (!cur_out_valid || out_ready)) begin
                errors++;
                $display("FAIL %s in_ready cyc=%0d: got %b want %b", name, cyc,
                         cur_in_ready, !cur_out_valid || out_ready);
            end
            if (cur_out_valid && out_ready) begin
                got = {cur_last, cur_cout, cur_ovf, cur_sum};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra beat: got %h want none", name, got);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (got !== exp_v) begin
                        errors++;
                        $display("FAIL %s beat {last,cout,ovf,sum}: got %h want %h", name, got, exp_v);
                    end
                end
            end
            if (in_valid && cur_in_ready) idx++;
            cyc++;
        end
        checks++;
        if (cyc >= max_cycles) begin
            errors++;
            $display("FAIL %s timeout: got %0d beats pending want 0", name, exp_q.size());
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (cur_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s drained out_valid: got %b want 0", name, cur_out_valid);
        end
        stim_a.delete(); stim_b.delete(); stim_cin.delete(); stim_last.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sel = (k == 0) ? 1 : (k == 1) ? 2 : 4;
            #1;
            checks += 4;
            if (cur_out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid w%0d: got %b want 0", sel, cur_out_valid); end
            if (cur_in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready w%0d: got %b want 1", sel, cur_in_ready); end
            if (cur_len_err !== 1'b0) begin errors++; $display("FAIL reset len_err w%0d: got %b want 0", sel, cur_len_err); end
            if ({cur_last, cur_cout, cur_ovf, cur_sum} !== 19'h0) begin
                errors++; $display("FAIL reset data w%0d: got %h want 0", sel, {cur_last, cur_cout, cur_ovf, cur_sum});
            end
        end
    endtask

    task automatic test_chained_carry();
        sel = 2;
        push(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        push(16'h0001, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b0);
        run_stream("chained_carry", 0, 50);
    endtask

    task automatic test_single_beat_ovf();
        sel = 1;
        push(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        push(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_stream("single_ovf", 0, 50);
        checks++;
        if (cur_len_err !== 1'b0) begin errors++; $display("FAIL single_ovf len_err: got %b want 0", cur_len_err); end
    endtask

    task automatic test_backpressure();
        sel = 4;
        // cin on later beats is 0 and must be ignored; the chain carry keeps cout=1.
        push(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        push(16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        push(16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        push(16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_stream("backpressure", 1, 100);
    endtask

    task automatic test_length_violation();
        sel = 2;
        push(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        // Forced close: carry-out 1 must not leak into the next packet.
        push(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        push(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0009, 1'b0, 1'b1, 1'b0);
        run_stream("length_violation", 0, 50);
        checks++;
        if (cur_len_err !== 1'b1) begin errors++; $display("FAIL length_violation len_err: got %b want 1", cur_len_err); end
        repeat (3) @(negedge clk);
        checks++;
        if (cur_len_err !== 1'b1) begin errors++; $display("FAIL length_violation sticky: got %b want 1", cur_len_err); end
    endtask

    task automatic test_reset_mid_packet();
        sel = 4;
        push(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        push(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
        run_stream("reset_mid_pre", 0, 50);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks += 2;
        if ({cur_out_valid, cur_cout, cur_sum} !== 18'h0) begin
            errors++; $display("FAIL reset_mid async: got %h want 0", {cur_out_valid, cur_cout, cur_sum});
        end
        sel = 2;
        #0;
        if (cur_len_err !== 1'b0) begin errors++; $display("FAIL reset_mid len_err: got %b want 0", cur_len_err); end
        sel = 4;
        @(negedge clk);
        rst = 1'b0;
        push(16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b0);
        run_stream("reset_mid_post", 0, 50);
    endtask

    task automatic test_back_to_back();
        sel = 4;
        push(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
        push(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        push(16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1);
        push(16'h0001, 16'h0002, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b0);
        run_stream("back_to_back", 0, 50);
    endtask

    task automatic test_random_ready();
        sel = 4;
        push(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        push(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        push(16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        push(16'h4000, 16'h4000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1);
        push(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        run_stream("random_ready", 2, 400);
    endtask

    initial begin
        test_reset();
        test_chained_carry();
        test_single_beat_ovf();
        test_backpressure();
        test_length_violation();
        test_reset_mid_packet();
        test_back_to_back();
        test_random_ready();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multiword_add_seq16.md
# multiword_add_seq16

Sequential front-end for the 16-bit carry-select adder (`carry_select_adder16`). It adds two operands wider than 16 bits by streaming them in as 16-bit beats, least-significant beat first. It feeds each beat to one adder instance and chains the adder's `cout` into the next beat's `cin`. It returns one registered 16-bit sum beat per input beat, under a valid/ready handshake on both sides.

## Interface
- `WORDS`, default 4: maximum beats per operand (operand width = 16*`WORDS`); legal range 1..256.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `in_a`  in  16  operand A beat.
- `in_b`  in  16  operand B beat.
- `in_cin`  in  1  carry-in for the operand; sampled only on the first beat of a packet.
- `in_last`  in  1  marks the most-significant beat of the packet.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts the output beat.
- `out_sum`  out  16  sum beat.
- `out_last`  out  1  last beat of the packet (from `in_last` or a forced close).
- `out_cout`  out  1  adder carry-out of this beat; meaningful as the packet carry when `out_last` = 1.
- `out_ovf`  out  1  signed overflow of the full-width sum; valid only when `out_last` = 1, otherwise 0.
- `len_err`  out  1  sticky: a packet exceeded `WORDS` beats; cleared only by `rst`.

## Operation
- **Accept:** a beat is accepted when `in_valid` && `in_ready`.
- **Ready:** `in_ready` = !`out_valid` || `out_ready`. This is a single output register with pass-through readiness and no skid buffer.
- **Internal state:**
  - `first` flag (reset 1).
  - `carry` register (reset 0).
  - beat counter `cnt`, width clog2(`WORDS`)+1 (reset 0).
- **Adder carry-in:** `cin` = `first` ? `in_cin` : `carry`. The adder is combinational on `in_a`, `in_b` and that `cin`.
- **On accept:**
  - `out_sum` <= sum.
  - `out_cout` <= `cout`.
  - `carry` <= `cout`.
  - `out_valid` <= 1.
  - `cnt` <= `cnt`+1.
  - `first` <= 0.
- **Packet close:** the packet closes if `in_last` = 1 or `cnt` == `WORDS`-1.
  - On close: `out_last` <= 1, `first` <= 1, `cnt` <= 0, `carry` <= 0.
  - `out_ovf` <= (`in_a`[15] == `in_b`[15]) && (sum[15] != `in_a`[15]).
- **Forced close:** when the beat at `cnt` == `WORDS`-1 arrives with `in_last` = 0:
  - it is still closed as last;
  - `len_err` <= 1;
  - the following beats start a new packet.
- **Non-closing beats:** `out_last` <= 0 and `out_ovf` <= 0.
- **Output retire:** if `out_valid` && `out_ready` and no new accept in the same cycle, then `out_valid` <= 0. The data registers hold their values.
- **Hold under backpressure:** while `out_valid` && !`out_ready`, all output registers, `carry`, `first` and `cnt` hold. Input is stalled.
- **`WORDS` = 1:** every beat is a complete packet, and `in_last` is ignored for closing. `len_err` never sets, because `cnt` == 0 == `WORDS`-1 always closes.
- **Reset:**
  - Clears `out_valid`, `out_sum`, `out_last`, `out_cout`, `out_ovf`, `len_err`, `carry` and `cnt` to 0, and `first` to 1.
  - `in_ready` = 1 after reset.
  - Reset mid-packet discards the partial packet; the next accepted beat is a first beat.

## Timing
- Latency: exactly 1 cycle from accept to `out_valid`.
- Throughput: 1 beat/cycle when `out_ready` is held at 1.
- The combinational path is `in_*` → adder → output register. `in_ready` depends combinationally on `out_ready` only.
- Simultaneous retire + accept in one cycle: `out_valid` stays 1 and the data is replaced by the new beat.
- `in_cin` on non-first beats has no effect.

## Test plan
- **Chained carry:** `WORDS`=2, beats (A=0xFFFF, B=0x0001, cin=0), then (A=0x0001, B=0x0000, last) → outputs 0x0000/cout=1, then 0x0002/cout=0/last=1/ovf=0.
- **Single-beat signed overflow:** `WORDS`=1, A=0x7FFF, B=0x0001, cin=0 → `out_sum`=0x8000, `out_cout`=0, `out_ovf`=1, `out_last`=1. Repeat with A=0xFFFF, B=0x0000, cin=1 → sum 0x0000, cout=1, ovf=0.
- **Backpressure:** `WORDS`=4, 4-beat packet of all 0xFFFF + 0x0000 with cin=1, and `out_ready` toggled 1,0,0,1,… → every beat sum 0x0000/cout=1. No beat is lost or duplicated, `in_ready` is low whenever an output is pending and unaccepted, and `carry` is preserved across stalls.
- **Length violation:** `WORDS`=2, three beats with `in_last`=0,0,1 → beat 2 emitted with `out_last`=1 and `len_err`=1. Beat 3 is treated as first (uses its own `in_cin`) and emitted with `out_last`=1. `len_err` stays 1.
- **Reset mid-packet:** `WORDS`=4, accept 2 beats producing carry=1, assert `rst` asynchronously mid-cycle → outputs 0 immediately. Next beat 0x0001+0x0001 with cin=0 → `out_sum`=0x0002, with no stale carry.
- **Random streaming:** `out_ready` random, 10k packets of random length ≤ `WORDS` → concatenated sums, final carry and `out_ovf` match a 16*`WORDS`-bit reference model.
